// File: rtl/clock_setup_controller.sv
// Setup controller for a four-digit HH:MM clock: debounces four buttons and runs the
// RUN/SET/COMMIT/ABORT sequence that drives digit selection, adjust strobes and blinking.
module clock_setup_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int TIMEOUT_SEC     = 30
) (
    input  logic       M_CLOCK,
    input  logic       M_RESET_N,
    input  logic [3:0] PB,
    input  logic       sec_tick,
    output logic       setup_mode,
    output logic [1:0] loc,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       commit_pulse,
    output logic       abort_pulse,
    output logic       digit_blank
);

    localparam int DB_W = 20;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_CYCLES - 1);
    localparam logic [7:0]      IDLE_LAST = 8'(TIMEOUT_SEC - 1);

    typedef enum logic [1:0] {RUN, SET, COMMIT, ABORT} state_t;

    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [3:0] level;
    logic [3:0] press;

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= PB;
            sync_b <= sync_a;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    for (genvar g = 0; g < 4; g++) begin : g_debounce
        logic [DB_W-1:0] count;
        logic            stable;
        logic            event_q;

        always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
            if (!M_RESET_N) begin
                count   <= '0;
                stable  <= 1'b0;
                event_q <= 1'b0;
            end else begin
                event_q <= 1'b0;
                if (sync_b[g] != stable) begin
                    if (count == DB_LAST) begin
                        count   <= '0;
                        stable  <= sync_b[g];
                        event_q <= sync_b[g];
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    count <= '0;
                end
            end
        end

        assign level[g] = stable;
        assign press[g] = event_q;
    end

    state_t          state;
    state_t          state_next;
    logic [1:0]      loc_next;
    logic [7:0]      idle_count;
    logic [7:0]      idle_next;
    logic [BL_W-1:0] blink_count;
    logic [BL_W-1:0] blink_next;
    logic            blank_next;
    logic            inc_next;
    logic            dec_next;
    logic            commit_next;
    logic            abort_next;
    logic            any_press;
    logic            timeout;

    assign any_press = |press;
    assign timeout   = sec_tick && (idle_count == IDLE_LAST);

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            state        <= RUN;
            loc          <= 2'd3;
            idle_count   <= '0;
            blink_count  <= '0;
            setup_mode   <= 1'b0;
            digit_blank  <= 1'b0;
            inc_pulse    <= 1'b0;
            dec_pulse    <= 1'b0;
            commit_pulse <= 1'b0;
            abort_pulse  <= 1'b0;
        end else begin
            state        <= state_next;
            loc          <= loc_next;
            idle_count   <= idle_next;
            blink_count  <= blink_next;
            setup_mode   <= (state_next != RUN);
            digit_blank  <= blank_next;
            inc_pulse    <= inc_next;
            dec_pulse    <= dec_next;
            commit_pulse <= commit_next;
            abort_pulse  <= abort_next;
        end
    end

    // Exit decisions outrank digit moves, which outrank adjusts; losing events are dropped.
    always_comb begin
        state_next  = state;
        loc_next    = loc;
        idle_next   = idle_count;
        blink_next  = blink_count;
        blank_next  = 1'b0;
        inc_next    = 1'b0;
        dec_next    = 1'b0;
        commit_next = 1'b0;
        abort_next  = 1'b0;
        case (state)
            RUN: begin
                idle_next  = '0;
                blink_next = '0;
                if (press[0]) begin
                    state_next = SET;
                    loc_next   = 2'd3;
                end
            end
            SET: begin
                if (blink_count == BL_LAST) begin
                    blink_next = '0;
                    blank_next = ~digit_blank;
                end else begin
                    blink_next = blink_count + 1'b1;
                    blank_next = digit_blank;
                end
                if (any_press) begin
                    idle_next  = '0;
                    blink_next = '0;
                    blank_next = 1'b0;
                end else if (sec_tick) begin
                    idle_next = idle_count + 1'b1;
                end
                if (press[0]) begin
                    state_next  = COMMIT;
                    commit_next = 1'b1;
                    blank_next  = 1'b0;
                end else if (timeout) begin
                    state_next = ABORT;
                    abort_next = 1'b1;
                    blank_next = 1'b0;
                end else if (press[1]) begin
                    loc_next = loc - 2'd1;
                end else if (press[2] ^ press[3]) begin
                    inc_next = press[2];
                    dec_next = press[3];
                end
            end
            default: begin
                state_next = RUN;
                idle_next  = '0;
                blink_next = '0;
            end
        endcase
    end

    logic unused_level;
    assign unused_level = ^level;

endmodule

// File: doc/clock_setup_controller.md
CLOCK_SETUP_CONTROLLER -- requirements
Module: clock_setup_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a button level (legal range 2..2^20-1).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, meaning half-period, in clocks, of the selected-digit blink.
REQ-003 SHALL have parameter TIMEOUT_SEC, default 30, meaning idle sec_tick count in setup before abort (legal range 1..255).
REQ-004 SHALL have port M_CLOCK, input, width 1: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port M_RESET_N, input, width 1: reset, asynchronous, active-low.
REQ-006 SHALL have port PB, input, width 4: raw active-high buttons; [0]=mode/enter, [1]=next digit, [2]=increment, [3]=decrement; asynchronous to M_CLOCK.
REQ-007 SHALL have port sec_tick, input, width 1: one-cycle pulse once per second from the timekeeping counter.
REQ-008 SHALL have port setup_mode, output, width 1: high while in SET; freezes timekeeping.
REQ-009 SHALL have port loc, output, width 2: selected digit; 3=hour upper, 2=hour lower, 1=minute upper, 0=minute lower.
REQ-010 SHALL have ports inc_pulse and dec_pulse, outputs, width 1 each: one-cycle adjust strobes for the digit at loc.
REQ-011 SHALL have ports commit_pulse and abort_pulse, outputs, width 1 each: one-cycle setup-exit strobes.
REQ-012 SHALL have port digit_blank, output, width 1: high when the display driver must blank the digit at loc.

Function
REQ-013 Each PB bit SHALL pass through a 2-flop synchronizer and then an independent debouncer.
REQ-014 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts that bit's count.
REQ-015 A press event SHALL be a one-cycle pulse on a debounced 0->1 transition; release SHALL generate no event.
REQ-016 Latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles from a clean raw rise to the press event, and one more cycle to any registered output.
REQ-017 The FSM SHALL have states RUN, SET, COMMIT and ABORT.
REQ-018 In RUN, a PB[0] event SHALL go to SET with loc=3; all other events SHALL be ignored.
REQ-019 In SET, a PB[0] event SHALL go to COMMIT.
REQ-020 In SET, a PB[1] event SHALL decrement loc modulo 4 (3->2->1->0->3).
REQ-021 In SET, a PB[2] event SHALL pulse inc_pulse and a PB[3] event SHALL pulse dec_pulse.
REQ-022 Priority on simultaneous events SHALL be PB[0] > PB[1] > {PB[2],PB[3]}; PB[2] together with PB[3] SHALL produce no pulse; lower-priority events that lose SHALL be discarded, not queued.
REQ-023 COMMIT and ABORT SHALL each last exactly one cycle, assert commit_pulse or abort_pulse respectively, and return to RUN; loc SHALL hold its value.
REQ-024 The idle counter SHALL clear on SET entry and on every press event in SET, and SHALL increment on each sec_tick in SET.
REQ-025 When the idle counter reaches TIMEOUT_SEC, the FSM SHALL go to ABORT; a PB[0] event in that same cycle SHALL win and go to COMMIT.
REQ-026 setup_mode SHALL be 1 in SET, COMMIT and ABORT, and 0 in RUN.
REQ-027 digit_blank SHALL be 0 outside SET.
REQ-028 In SET, digit_blank SHALL toggle every BLINK_CYCLES cycles; the blink counter and digit_blank SHALL clear to 0 on SET entry and on every press event.
REQ-029 All outputs SHALL be registered and glitch-free.

Reset
REQ-030 Asserting M_RESET_N low SHALL immediately force the state to RUN, loc=3, all pulses=0, setup_mode=0 and digit_blank=0, and clear debounced levels, synchronizers and all counters to 0.
REQ-031 Reset asserted mid-SET SHALL abandon setup without commit_pulse or abort_pulse.
REQ-032 After release, a button already held SHALL produce exactly one press event, after DEBOUNCE_CYCLES+2 cycles.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_SEC=3)
REQ-033 PB[0] rise in RUN, held 10 cycles -> setup_mode=1 and loc=3, registered 7 cycles after the rise; a single event is produced.
REQ-034 In SET, PB[1] pressed 4 times -> loc goes 2,1,0,3; PB[2] press -> exactly one inc_pulse; PB[2]+PB[3] pressed together -> no pulses.
REQ-035 PB[2] bouncing with 1-3 cycle glitches for 20 cycles, then stable high -> exactly one inc_pulse.
REQ-036 SET with no presses, 3 sec_ticks -> one-cycle abort_pulse, then RUN; repeat with a PB[0] event coincident with the 3rd tick -> commit_pulse, no abort_pulse.
REQ-037 SET held idle -> digit_blank toggles every 8 cycles; a PB[1] press -> digit_blank=0 and the blink period restarts.
REQ-038 M_RESET_N low mid-SET with loc=1 -> outputs at reset values asynchronously, with no exit pulse.
